one_hot_mux_arbiter: RTL and testbench

ONE_HOT_MUX_ARBITER -- requirements
Module: one_hot_mux_arbiter

---
 rtl/one_hot_mux_arbiter.sv | 117 +++++++++++
 tb/tb_one_hot_mux_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/one_hot_mux_arbiter.sv
// Round-robin arbiter for four requesters with a bounded hold time.
// Its registered one-hot grant also selects the data bit that is forwarded to y_o.
module one_hot_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req_i,
  input  logic [3:0] last_i,
  input  logic [3:0] a_i,
  output logic [3:0] gnt_o,
  output logic       busy_o,
  output logic       y_o,
  output logic       valid_o
);

  localparam int unsigned N      = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                busy_q, y_q, valid_q;

  logic                pick_found;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    cand;
  logic [PTR_W-1:0]    cur_idx;
  logic                release_c;

  // First requester in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr_q + PTR_W'(i);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // ptr always sits one past the current grantee, so the grantee is ptr-1
  assign cur_idx   = ptr_q - PTR_W'(1);
  assign release_c = last_i[cur_idx] | ~req_i[cur_idx] | (hold_q == HOLD_W'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = N'(1) << pick_idx;
          ptr_d   = pick_idx + PTR_W'(1);
          hold_d  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!release_c) begin
          hold_d = hold_q + HOLD_W'(1);
        end else if (pick_found) begin
          gnt_d  = N'(1) << pick_idx;
          ptr_d  = pick_idx + PTR_W'(1);
          hold_d = HOLD_W'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= |gnt_d;
      // Data path lags the grant by one cycle
      y_q     <= |(a_i & gnt_q);
      valid_q <= |gnt_q;
    end
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = busy_q;
  assign y_o     = y_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_one_hot_mux_arbiter.sv
// Directed and random checks of the one-hot mux arbiter with MAX_HOLD = 4.
module tb_one_hot_mux_arbiter;

  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_i, last_i, a_i;
  logic [3:0] gnt_o;
  logic       busy_o, y_o, valid_o;

  int checks = 0;
  int errors = 0;

  one_hot_mux_arbiter #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req_i),
    .last_i  (last_i),
    .a_i     (a_i),
    .gnt_o   (gnt_o),
    .busy_o  (busy_o),
    .y_o     (y_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; pulses reset well before the next edge
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // Reference model state
  int         m_state, m_g, m_ptr, m_hold;
  logic [3:0] m_gnt;

  task automatic model_step(input logic [3:0] req, input logic [3:0] last);
    bit rel;
    rel = 1'b0;
    if (m_state == 1)
      rel = last[m_g] || !req[m_g] || (m_hold == int'(MH));
    if (m_state == 0 || rel) begin
      if (req != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (req[(m_ptr + k) % 4]) begin
            m_g = (m_ptr + k) % 4;
            break;
          end
        end
        m_ptr   = (m_g + 1) % 4;
        m_hold  = 1;
        m_state = 1;
      end else begin
        m_state = 0;
        m_hold  = 0;
      end
    end else begin
      m_hold++;
    end
    m_gnt = (m_state == 1) ? (4'b0001 << m_g) : 4'b0000;
  endtask

  initial begin
    logic [3:0] prev_gnt, prev_a, rq, ls;

    reset_n = 1'b0;
    req_i = '0; last_i = '0; a_i = '0;
    #2;
    chk("reset_gnt", gnt_o, 4'b0000);
    chk("reset_busy", {3'b0, busy_o}, 4'b0000);
    chk("reset_y", {3'b0, y_o}, 4'b0000);
    chk("reset_valid", {3'b0, valid_o}, 4'b0000);
    #1 reset_n = 1'b1;

    // Single requester held past MAX_HOLD: regranted without a gap
    tick();
    req_i = 4'b0100; a_i = 4'b0100; last_i = 4'b0000;
    tick();
    chk("single_c1_gnt", gnt_o, 4'b0100);
    chk("single_c1_busy", {3'b0, busy_o}, 4'b0001);
    chk("single_c1_valid", {3'b0, valid_o}, 4'b0000);
    tick();
    chk("single_c2_gnt", gnt_o, 4'b0100);
    chk("single_c2_y", {3'b0, y_o}, 4'b0001);
    chk("single_c2_valid", {3'b0, valid_o}, 4'b0001);
    tick(); chk("single_c3_gnt", gnt_o, 4'b0100);
    tick(); chk("single_c4_gnt", gnt_o, 4'b0100);
    tick(); chk("single_c5_gnt", gnt_o, 4'b0100);
    chk("single_c5_y", {3'b0, y_o}, 4'b0001);

    // Hold limit forces a handover between two persistent requesters
    req_i = 4'b0000; a_i = 4'b0000;
    do_reset();
    req_i = 4'b0011;
    tick(); chk("hold_c1", gnt_o, 4'b0001);
    tick(); tick(); tick(); chk("hold_c4", gnt_o, 4'b0001);
    tick(); chk("hold_c5", gnt_o, 4'b0010);
    tick(); tick(); tick(); chk("hold_c8", gnt_o, 4'b0010);
    tick(); chk("hold_c9", gnt_o, 4'b0001);

    // All requesting with last high: one cycle each in rotation
    req_i = 4'b0000;
    do_reset();
    req_i = 4'b1111; last_i = 4'b1111;
    tick(); chk("all_c1", gnt_o, 4'b0001); chk("all_busy1", {3'b0, busy_o}, 4'b0001);
    tick(); chk("all_c2", gnt_o, 4'b0010); chk("all_busy2", {3'b0, busy_o}, 4'b0001);
    tick(); chk("all_c3", gnt_o, 4'b0100); chk("all_busy3", {3'b0, busy_o}, 4'b0001);
    tick(); chk("all_c4", gnt_o, 4'b1000); chk("all_busy4", {3'b0, busy_o}, 4'b0001);
    tick(); chk("all_c5", gnt_o, 4'b0001); chk("all_busy5", {3'b0, busy_o}, 4'b0001);

    // Skipping non-requesters
    req_i = 4'b0000;
    do_reset();
    req_i = 4'b1010; last_i = 4'b1111;
    tick(); chk("skip_c1", gnt_o, 4'b0010);
    tick(); chk("skip_c2", gnt_o, 4'b1000);
    tick(); chk("skip_c3", gnt_o, 4'b0010);

    // Request drop returns to idle; ptr then stays put while idle
    req_i = 4'b0000;
    do_reset();
    req_i = 4'b0010; last_i = 4'b0000; a_i = 4'b0010;
    tick(); chk("drop_c1", gnt_o, 4'b0010);
    req_i = 4'b0000; last_i = 4'b1111;
    tick();
    chk("drop_c2_gnt", gnt_o, 4'b0000);
    chk("drop_c2_busy", {3'b0, busy_o}, 4'b0000);
    chk("drop_c2_valid", {3'b0, valid_o}, 4'b0001);
    chk("drop_c2_y", {3'b0, y_o}, 4'b0001);
    tick();
    chk("drop_c3_valid", {3'b0, valid_o}, 4'b0000);
    chk("drop_c3_y", {3'b0, y_o}, 4'b0000);
    tick(); chk("idle_hold", gnt_o, 4'b0000);
    req_i = 4'b0111; last_i = 4'b0000;
    tick(); chk("idle_ptr_kept", gnt_o, 4'b0100);

    // Asynchronous reset mid-grant, then search restarts at index 0
    req_i = 4'b0000;
    do_reset();
    req_i = 4'b1000; a_i = 4'b1000;
    tick(); chk("rst_c1", gnt_o, 4'b1000);
    tick();
    chk("rst_c2_y", {3'b0, y_o}, 4'b0001);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_gnt", gnt_o, 4'b0000);
    chk("rst_async_y", {3'b0, y_o}, 4'b0000);
    chk("rst_async_valid", {3'b0, valid_o}, 4'b0000);
    chk("rst_async_busy", {3'b0, busy_o}, 4'b0000);
    req_i = 4'b1001;
    #2 reset_n = 1'b1;
    tick(); chk("rst_after", gnt_o, 4'b0001);

    // Random traffic against the reference model
    req_i = 4'b0000; last_i = 4'b0000; a_i = 4'b0000;
    do_reset();
    m_state = 0; m_g = 0; m_ptr = 0; m_hold = 0; m_gnt = 4'b0000;
    for (int n = 0; n < 1000; n++) begin
      rq = 4'($urandom_range(0, 15));
      ls = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      req_i  = rq;
      last_i = ls;
      a_i    = 4'($urandom_range(0, 15));
      prev_gnt = m_gnt;
      prev_a   = a_i;
      tick();
      model_step(rq, ls);
      chk("rnd_onehot", {3'b0, $onehot0(gnt_o)}, 4'b0001);
      chk("rnd_gnt", gnt_o, m_gnt);
      chk("rnd_y", {3'b0, y_o}, {3'b0, |(prev_a & prev_gnt)});
      chk("rnd_valid", {3'b0, valid_o}, {3'b0, |prev_gnt});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
